// File: rtl/data_upsampler_pkg.sv
// Shared rate encodings, line width and slice-count helper for the TX upsampler.
package data_upsampler_pkg;

    localparam int LINE_W = 32;

    localparam logic [1:0] RATE_4X = 2'b00;
    localparam logic [1:0] RATE_2X = 2'b01;
    localparam logic [1:0] RATE_1X = 2'b10;

    // Number of line words one payload word occupies at a given rate.
    function automatic logic [2:0] slices_per_word(input logic [1:0] rate);
        case (rate)
            RATE_4X: slices_per_word = 3'd4;
            RATE_2X: slices_per_word = 3'd2;
            default: slices_per_word = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/data_upsampler_if.sv
// Payload input handshake: a word transfers on any rx_clk edge where din_valid and din_ready are both high.
interface data_upsampler_if;
    import data_upsampler_pkg::*;

    logic [LINE_W-1:0] din;
    logic              din_valid;
    logic              din_ready;

    modport master (output din, output din_valid, input din_ready);
    modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/data_upsampler_expand.sv
// upsample_expand: combinational slice selector and bit replicator, shared by payload and idle paths.
module upsample_expand
    import data_upsampler_pkg::*;
(
    input  logic [LINE_W-1:0] i_word,
    input  logic [1:0]        i_cnt,
    input  logic [1:0]        i_rate,
    output logic [LINE_W-1:0] o_line
);

    always_comb begin
        o_line = i_word;
        case (i_rate)
            RATE_4X: begin
                for (int i = 0; i < 8; i++) begin
                    o_line[4*i +: 4] = {4{i_word[{i_cnt, 3'b000} + 5'(i)]}};
                end
            end
            RATE_2X: begin
                for (int i = 0; i < 16; i++) begin
                    o_line[2*i +: 2] = {2{i_word[{i_cnt[0], 4'b0000} + 5'(i)]}};
                end
            end
            default: o_line = i_word;
        endcase
    end

endmodule

// File: rtl/data_upsampler.sv
// data_upsampler: 2-entry FIFO feeding a 4x/2x/1x bit replicator onto a fixed-rate GTX TX word.
// Optional build macro DATA_UPSAMPLER_PRBS_EN replaces the constant idle fill with PRBS7.
module data_upsampler
    import data_upsampler_pkg::*;
#(
    parameter logic [31:0] IDLE_WORD = 32'h0000_0000,
    parameter int          CNT_W     = 16
) (
    input  logic               rx_clk,
    input  logic               reset,
    input  logic [1:0]         rate,
    data_upsampler_if.slave    s_in,
    output logic [LINE_W-1:0]  dout,
    output logic               busy,
    output logic               underflow,
    output logic [CNT_W-1:0]   word_cnt
);

    logic [LINE_W-1:0] r_mem [2];
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [1:0]        r_count;
    logic [1:0]        r_cnt;
    logic [1:0]        r_rate_q;
    logic [LINE_W-1:0] r_dout;
    logic              r_underflow;
    logic              r_popped;
    logic [CNT_W-1:0]  r_word_cnt;
    logic              r_ready_en;

    logic [1:0]        w_rate_in;
    logic [1:0]        w_rate;
    logic [2:0]        w_slices;
    logic              w_last;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;
    logic [LINE_W-1:0] w_head;
    logic [LINE_W-1:0] w_idle_src;
    logic [LINE_W-1:0] w_data_line;
    logic [LINE_W-1:0] w_idle_line;

    // A new rate only applies at a word boundary; mid-word the latched rate holds.
    assign w_rate_in = (rate == 2'b11) ? RATE_1X : rate;
    assign w_rate    = (r_cnt == 2'd0) ? w_rate_in : r_rate_q;
    assign w_slices  = slices_per_word(w_rate);
    assign w_last    = ({1'b0, r_cnt} == (w_slices - 3'd1));

    assign w_empty = (r_count == 2'd0);
    assign w_full  = (r_count == 2'd2);
    assign s_in.din_ready = r_ready_en & ~w_full;
    assign w_push  = s_in.din_valid & s_in.din_ready;
    assign w_pop   = ~w_empty & w_last;
    assign w_head  = r_mem[r_rd_ptr];

`ifdef DATA_UPSAMPLER_PRBS_EN
    logic [6:0] r_lfsr;
    logic [6:0] w_lfsr_nxt;
    logic [31:0] w_prbs_word;

    // PRBS7 x^7+x^6+1, 32 bits unrolled; the state is kept after 8/16/32 steps by rate.
    always_comb begin
        logic [6:0] v_s;
        logic       v_nb;
        v_s         = r_lfsr;
        v_nb        = 1'b0;
        w_prbs_word = '0;
        w_lfsr_nxt  = r_lfsr;
        for (int k = 0; k < 32; k++) begin
            v_nb           = v_s[6] ^ v_s[5];
            w_prbs_word[k] = v_nb;
            v_s            = {v_s[5:0], v_nb};
            if ((k == 7)  && (w_rate == RATE_4X)) w_lfsr_nxt = v_s;
            if ((k == 15) && (w_rate == RATE_2X)) w_lfsr_nxt = v_s;
            if ((k == 31) && (w_rate == RATE_1X)) w_lfsr_nxt = v_s;
        end
    end

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_lfsr <= 7'h7F;
        end else if (w_empty) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end

    assign w_idle_src = w_prbs_word;
`else
    assign w_idle_src = IDLE_WORD;
`endif

    upsample_expand u_exp_data (
        .i_word (w_head),
        .i_cnt  (r_cnt),
        .i_rate (w_rate),
        .o_line (w_data_line)
    );

    upsample_expand u_exp_idle (
        .i_word (w_idle_src),
        .i_cnt  (r_cnt),
        .i_rate (w_rate),
        .o_line (w_idle_line)
    );

    always_ff @(posedge rx_clk) begin
        if (reset) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_cnt       <= 2'd0;
            r_rate_q    <= RATE_1X;
            r_dout      <= '0;
            r_underflow <= 1'b0;
            r_popped    <= 1'b0;
            r_word_cnt  <= '0;
            r_ready_en  <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (r_cnt == 2'd0) r_rate_q <= w_rate_in;

            if (w_push) begin
                r_mem[r_wr_ptr] <= s_in.din;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase

            if (w_empty) begin
                r_dout <= w_idle_line;
                r_cnt  <= 2'd0;
            end else begin
                r_dout <= w_data_line;
                r_cnt  <= w_last ? 2'd0 : r_cnt + 2'd1;
            end

            if (w_pop) begin
                r_popped <= 1'b1;
                if (r_word_cnt != {CNT_W{1'b1}}) r_word_cnt <= r_word_cnt + 1'b1;
            end
            if (w_empty && r_popped) r_underflow <= 1'b1;
        end
    end

    assign dout      = r_dout;
    assign busy      = ~w_empty;
    assign underflow = r_underflow;
    assign word_cnt  = r_word_cnt;

endmodule

// File: tb/tb_data_upsampler.sv
// Self-checking bench for data_upsampler: vector table plus directed multi-cycle sequences.
module tb_data_upsampler;

    logic        rx_clk = 1'b0;
    logic        reset  = 1'b1;
    logic [1:0]  rate   = 2'b10;
    logic [31:0] dout;
    logic        busy;
    logic        underflow;
    logic [15:0] word_cnt;

    data_upsampler_if u_if ();

    data_upsampler #(.IDLE_WORD(32'h0000_0000), .CNT_W(16)) dut (
        .rx_clk    (rx_clk),
        .reset     (reset),
        .rate      (rate),
        .s_in      (u_if),
        .dout      (dout),
        .busy      (busy),
        .underflow (underflow),
        .word_cnt  (word_cnt)
    );

    always #5 rx_clk = ~rx_clk;

    int          checks   = 0;
    int          failures = 0;
    int          exp_wc   = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  rate;
        logic [31:0] din;
        logic [31:0] exp_s0;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int spw(input logic [1:0] r);
        if (r == 2'b00) return 4;
        if (r == 2'b01) return 2;
        return 1;
    endfunction

    // Output bit j of slice c carries payload bit c*B + j/R, B bits per slice, R-fold replication.
    function automatic logic [31:0] model_slice(input logic [1:0] r, input logic [31:0] w, input int c);
        logic [31:0] res;
        int s, b;
        s = spw(r);
        b = 32 / s;
        res = '0;
        for (int j = 0; j < 32; j++) res[j] = w[c*b + j/s];
        return res;
    endfunction

    task automatic step_cmp(input string name);
        @(posedge rx_clk);
        @(negedge rx_clk);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s actual=no_expectation required=queued_value", name);
        end else begin
            check(name, dout, exp_q.pop_front());
        end
    endtask

    task automatic do_reset();
        @(negedge rx_clk);
        reset = 1'b1;
        u_if.din_valid = 1'b0;
        @(posedge rx_clk);
        @(negedge rx_clk);
        reset = 1'b0;
        exp_wc = 0;
        exp_q.delete();
        @(posedge rx_clk);
        @(negedge rx_clk);
    endtask

    logic [31:0] words[3];
    logic        rdy;
    int          idx;
    int          low;

    initial begin
        u_if.din       = '0;
        u_if.din_valid = 1'b0;

        vecs[0] = '{2'b00, 32'h0000_00A5, 32'hF0F0_0F0F};
        vecs[1] = '{2'b01, 32'h0000_FFFF, 32'hFFFF_FFFF};
        vecs[2] = '{2'b10, 32'h1234_5678, 32'h1234_5678};
        vecs[3] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4] = '{2'b01, 32'h0000_0001, 32'h0000_0003};
        vecs[5] = '{2'b11, 32'hCAFE_0080, 32'hCAFE_0080};

        // Reset state
        @(posedge rx_clk);
        @(negedge rx_clk);
        check("rst_dout", dout, 32'h0);
        check("rst_ready", {31'b0, u_if.din_ready}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_underflow", {31'b0, underflow}, 32'h0);
        check("rst_word_cnt", {16'b0, word_cnt}, 32'h0);
        reset = 1'b0;
        @(posedge rx_clk);
        @(negedge rx_clk);
        check("post_rst_ready", {31'b0, u_if.din_ready}, 32'h1);
        check("post_rst_underflow", {31'b0, underflow}, 32'h0);

        // Single words at each rate
        for (int v = 0; v < 6; v++) begin
            int s;
            s = spw(vecs[v].rate);
            rate = vecs[v].rate;
            u_if.din = vecs[v].din;
            u_if.din_valid = 1'b1;
            exp_q.push_back(vecs[v].exp_s0);
            for (int c = 1; c < s; c++) exp_q.push_back(model_slice(vecs[v].rate, vecs[v].din, c));
            exp_q.push_back(32'h0);
            @(posedge rx_clk);
            #1 u_if.din_valid = 1'b0;
            for (int k = 0; k < s + 1; k++) step_cmp($sformatf("vec%0d_slice%0d", v, k));
            exp_wc++;
            check($sformatf("vec%0d_word_cnt", v), {16'b0, word_cnt}, exp_wc);
            check($sformatf("vec%0d_busy", v), {31'b0, busy}, 32'h0);
            check($sformatf("vec%0d_underflow", v), {31'b0, underflow}, 32'h1);
        end

        // Back-to-back 1x stream
        do_reset();
        check("b2b_pre_underflow", {31'b0, underflow}, 32'h0);
        rate = 2'b10;
        u_if.din = 32'h1234_5678;
        u_if.din_valid = 1'b1;
        exp_q.push_back(32'h1234_5678);
        exp_q.push_back(32'h9ABC_DEF0);
        exp_q.push_back(32'h0);
        @(posedge rx_clk);
        #1 u_if.din = 32'h9ABC_DEF0;
        @(negedge rx_clk);
        check("b2b_ready", {31'b0, u_if.din_ready}, 32'h1);
        check("b2b_busy", {31'b0, busy}, 32'h1);
        @(posedge rx_clk);
        #1 u_if.din_valid = 1'b0;
        @(negedge rx_clk);
        check("b2b_w0", dout, exp_q.pop_front());
        check("b2b_uf0", {31'b0, underflow}, 32'h0);
        step_cmp("b2b_w1");
        check("b2b_uf1", {31'b0, underflow}, 32'h0);
        step_cmp("b2b_idle");
        @(posedge rx_clk);
        @(negedge rx_clk);
        check("b2b_uf_after", {31'b0, underflow}, 32'h1);
        exp_wc += 2;
        check("b2b_word_cnt", {16'b0, word_cnt}, exp_wc);

        // Rate change mid-word applies at the next word
        rate = 2'b00;
        u_if.din = 32'h8421_C3A5;
        u_if.din_valid = 1'b1;
        for (int c = 0; c < 4; c++) exp_q.push_back(model_slice(2'b00, 32'h8421_C3A5, c));
        exp_q.push_back(32'h5A5A_0FF0);
        exp_q.push_back(32'h0);
        @(posedge rx_clk);
        @(negedge rx_clk);
        u_if.din_valid = 1'b0;
        step_cmp("rchg_s0");
        step_cmp("rchg_s1");
        rate = 2'b10;
        u_if.din = 32'h5A5A_0FF0;
        u_if.din_valid = 1'b1;
        step_cmp("rchg_s2");
        u_if.din_valid = 1'b0;
        step_cmp("rchg_s3");
        step_cmp("rchg_raw");
        step_cmp("rchg_idle");
        exp_wc += 2;
        check("rchg_word_cnt", {16'b0, word_cnt}, exp_wc);

        // Full FIFO back-pressure at 4x with valid held
        words[0] = 32'h0000_00A5;
        words[1] = 32'h0F0F_3C81;
        words[2] = 32'hDEAD_BEEF;
        rate = 2'b00;
        for (int w = 0; w < 3; w++)
            for (int c = 0; c < 4; c++) exp_q.push_back(model_slice(2'b00, words[w], c));
        exp_q.push_back(32'h0);
        idx = 0;
        low = 0;
        rdy = 1'b0;
        u_if.din = words[0];
        u_if.din_valid = 1'b1;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (u_if.din_valid) begin
                rdy = u_if.din_ready;
                if (!rdy) low++;
            end
            @(posedge rx_clk);
            #1;
            if (u_if.din_valid && rdy) begin
                idx++;
                if (idx == 3) u_if.din_valid = 1'b0;
                else u_if.din = words[idx];
            end
            @(negedge rx_clk);
            if (cyc >= 1 && exp_q.size() > 0) check($sformatf("full_c%0d", cyc), dout, exp_q.pop_front());
        end
        check("full_ready_low_cycles", low, 3);
        check("full_accepted", idx, 3);
        check("full_queue_drained", exp_q.size(), 0);
        exp_wc += 3;
        check("full_word_cnt", {16'b0, word_cnt}, exp_wc);

        // Reset mid-word discards everything
        rate = 2'b00;
        u_if.din = 32'hFFFF_FFFF;
        u_if.din_valid = 1'b1;
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        @(posedge rx_clk);
        @(negedge rx_clk);
        u_if.din_valid = 1'b0;
        step_cmp("rmid_s0");
        step_cmp("rmid_s1");
        reset = 1'b1;
        @(posedge rx_clk);
        @(negedge rx_clk);
        check("rmid_dout", dout, 32'h0);
        check("rmid_busy", {31'b0, busy}, 32'h0);
        check("rmid_underflow", {31'b0, underflow}, 32'h0);
        check("rmid_word_cnt", {16'b0, word_cnt}, 32'h0);
        check("rmid_ready", {31'b0, u_if.din_ready}, 32'h0);
        reset = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        step_cmp("rmid_idle0");
        step_cmp("rmid_idle1");
        step_cmp("rmid_idle2");
        check("rmid_idle_busy", {31'b0, busy}, 32'h0);
        check("rmid_idle_underflow", {31'b0, underflow}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
